// File: rtl/load_use_scoreboard.sv
`default_nettype none
// load_use_scoreboard: multi-slot decode hazard unit with a per-register load countdown scoreboard.
// Revision 1.0 - initial release.
module load_use_scoreboard #(
  parameter int ISSUE_WIDTH = 2,
  parameter int REG_ADDR_W  = 5,
  parameter int LOAD_LAT    = 1,
  parameter int CNT_W       = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [ISSUE_WIDTH-1:0]            id_valid,
  input  logic [ISSUE_WIDTH*REG_ADDR_W-1:0] id_rs,
  input  logic [ISSUE_WIDTH*REG_ADDR_W-1:0] id_rt,
  input  logic [ISSUE_WIDTH-1:0]            id_uses_rs,
  input  logic [ISSUE_WIDTH-1:0]            id_uses_rt,
  input  logic [ISSUE_WIDTH*REG_ADDR_W-1:0] id_rd,
  input  logic [ISSUE_WIDTH-1:0]            id_rd_we,
  input  logic [ISSUE_WIDTH-1:0]            id_is_load,
  input  logic                              ex_hold,
  input  logic                              flush,
  output logic [ISSUE_WIDTH-1:0]            issue_mask,
  output logic [$clog2(ISSUE_WIDTH+1)-1:0]  issue_count,
  output logic                              pc_write,
  output logic                              ifid_write,
  output logic                              ctrl_bubble,
  output logic [CNT_W-1:0]                  stall_count
);

  localparam int NUM_REGS = 2**REG_ADDR_W;
  localparam int SB_W     = $clog2(LOAD_LAT+1);
  localparam int IC_W     = $clog2(ISSUE_WIDTH+1);
  localparam logic [SB_W-1:0] SB_LOAD = SB_W'(LOAD_LAT);

  logic [SB_W-1:0]        sb_cnt  [NUM_REGS];
  logic [SB_W-1:0]        sb_next [NUM_REGS];
  logic [NUM_REGS-1:0]    pending;
  logic [ISSUE_WIDTH-1:0] blocked;
  logic                   stop;
  logic                   stall_event;

  // Register 0 is never loaded, so its counter stays zero and never reports pending.
  generate
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_pend
      assign pending[r] = (sb_cnt[r] != '0);
    end
  endgenerate

  generate
    for (genvar i = 0; i < ISSUE_WIDTH; i++) begin : g_slot
      logic [REG_ADDR_W-1:0] rs;
      logic [REG_ADDR_W-1:0] rt;
      logic [REG_ADDR_W-1:0] rd;
      logic                  rs_live;
      logic                  rt_live;
      logic                  raw_sb;
      logic                  waw_sb;
      logic                  raw_intra;

      assign rs      = id_rs[i*REG_ADDR_W +: REG_ADDR_W];
      assign rt      = id_rt[i*REG_ADDR_W +: REG_ADDR_W];
      assign rd      = id_rd[i*REG_ADDR_W +: REG_ADDR_W];
      assign rs_live = id_uses_rs[i] && (rs != '0);
      assign rt_live = id_uses_rt[i] && (rt != '0);
      assign raw_sb  = (rs_live && pending[rs]) || (rt_live && pending[rt]);
      assign waw_sb  = id_rd_we[i] && (rd != '0) && pending[rd];

      // No forwarding between slots of one bundle: any older in-bundle writer blocks a reader.
      always_comb begin
        raw_intra = 1'b0;
        for (int j = 0; j < i; j++) begin
          if (id_valid[j] && id_rd_we[j]) begin
            if (rs_live && (id_rd[j*REG_ADDR_W +: REG_ADDR_W] == rs)) raw_intra = 1'b1;
            if (rt_live && (id_rd[j*REG_ADDR_W +: REG_ADDR_W] == rt)) raw_intra = 1'b1;
          end
        end
      end

      assign blocked[i] = id_valid[i] && (raw_sb || waw_sb || raw_intra);
    end
  endgenerate

  always_comb begin
    issue_mask = '0;
    stop       = ex_hold || flush;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      stop          = stop || blocked[i];
      issue_mask[i] = id_valid[i] && !stop;
    end
  end

  always_comb begin
    issue_count = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      issue_count = issue_count + IC_W'(issue_mask[i]);
    end
  end

  assign pc_write    = !ex_hold && (flush || (issue_mask == id_valid));
  assign ifid_write  = pc_write;
  assign ctrl_bubble = id_valid[0] && !issue_mask[0] && !flush;

  // Age every counter, then let issuing loads reload theirs (set wins over decrement).
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      sb_next[r] = pending[r] ? (sb_cnt[r] - SB_W'(1)) : '0;
    end
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      if (issue_mask[i] && id_is_load[i] && id_rd_we[i] &&
          (id_rd[i*REG_ADDR_W +: REG_ADDR_W] != '0)) begin
        sb_next[id_rd[i*REG_ADDR_W +: REG_ADDR_W]] = SB_LOAD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) sb_cnt[r] <= '0;
    end else if (!ex_hold) begin
      for (int r = 0; r < NUM_REGS; r++) sb_cnt[r] <= sb_next[r];
    end
  end

  assign stall_event = !ex_hold && !flush && ((id_valid & ~issue_mask) != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall_event && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire
